// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with 16x oversampling, majority vote and show-ahead receive FIFO
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                   clk_r,
    input  logic                   r_r,
    input  logic                   d_in,
    input  logic [DIV_W-1:0]       div,
    input  logic [1:0]             d_len,
    input  logic [1:0]             para,
    input  logic                   s_num,
    input  logic                   rd_en,
    input  logic                   ovr_clr,
    output logic [7:0]             data_out,
    output logic                   err_p,
    output logic                   err_frame,
    output logic                   rx_brk,
    output logic                   rx_valid,
    output logic                   err_ovr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t           state;
    logic             d_m, d_s;
    logic [DIV_W-1:0] bcnt, div_l;
    logic [3:0]       os;
    logic [1:0]       len_l, par_l;
    logic             stop_l, stop_idx;
    logic [2:0]       n;
    logic [7:0]       data;
    logic             perr, pbit;
    logic             s0, s1;
    logic             tick, mid, bit_end, bitv, push, exp_par;
    logic [10:0]      entry;

    logic [10:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             full, pop, wr_ok;
    logic [10:0]      head;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk_r) begin
        if (r_r) begin
            d_m <= 1'b1;
            d_s <= 1'b1;
        end else begin
            d_m <= d_in;
            d_s <= d_m;
        end
    end

    // Oversample timing, majority resolve and the push decision for the last stop bit
    always_comb begin
        tick    = (state inside {START, DATA, PAR, STOP}) && (bcnt == div_l);
        mid     = tick && (os == 4'd9);
        bit_end = tick && (os == 4'd15);
        bitv    = (s0 & s1) | (s0 & d_s) | (s1 & d_s);
        exp_par = (par_l == 2'b10) ? ^data : ~^data;
        push    = (state == STOP) && mid && (!bitv || (stop_idx == stop_l));
        entry   = {(!bitv && (data == 8'h00) && !pbit), !bitv, perr, data};
    end

    // Frame FSM: baud/oversample counters, bit capture and per-frame configuration
    always_ff @(posedge clk_r) begin
        if (r_r) begin
            state    <= IDLE;
            bcnt     <= '0;
            div_l    <= '0;
            os       <= 4'd0;
            len_l    <= 2'd0;
            par_l    <= 2'd0;
            stop_l   <= 1'b0;
            stop_idx <= 1'b0;
            n        <= 3'd0;
            data     <= 8'h00;
            perr     <= 1'b0;
            pbit     <= 1'b0;
            s0       <= 1'b0;
            s1       <= 1'b0;
        end else begin
            if (state == IDLE || state == WAIT_HI || bcnt == div_l)
                bcnt <= '0;
            else
                bcnt <= bcnt + DIV_W'(1);
            if (tick) begin
                os <= os + 4'd1;
                if (os == 4'd7) s0 <= d_s;
                if (os == 4'd8) s1 <= d_s;
            end
            case (state)
                IDLE: if (!d_s) begin
                    os       <= 4'd0;
                    div_l    <= div;
                    len_l    <= d_len;
                    par_l    <= para;
                    stop_l   <= s_num;
                    stop_idx <= 1'b0;
                    n        <= 3'd0;
                    data     <= 8'h00;
                    perr     <= 1'b0;
                    pbit     <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (mid && bitv)
                        state <= IDLE;
                    else if (bit_end)
                        state <= DATA;
                end
                DATA: begin
                    if (mid) data[n] <= bitv;
                    if (bit_end) begin
                        if (n == ({1'b0, len_l} + 3'd4))
                            state <= (par_l != 2'b00) ? PAR : STOP;
                        else
                            n <= n + 3'd1;
                    end
                end
                PAR: begin
                    if (mid) begin
                        pbit <= bitv;
                        perr <= (bitv != exp_par);
                    end
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (push)
                        state <= bitv ? IDLE : WAIT_HI;
                    else if (bit_end)
                        stop_idx <= 1'b1;
                end
                WAIT_HI: if (d_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        full  = (cnt == FULL);
        pop   = rd_en && (cnt != '0);
        wr_ok = push && (!full || pop);
    end

    // FIFO storage write; contents are only observed through the valid-gated head
    always_ff @(posedge clk_r) begin
        if (wr_ok) mem[wr_ptr] <= entry;
    end

    // FIFO pointers, occupancy and sticky overrun
    always_ff @(posedge clk_r) begin
        if (r_r) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            err_ovr <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (push && full && !pop)
                err_ovr <= 1'b1;
            else if (ovr_clr)
                err_ovr <= 1'b0;
        end
    end

    // Show-ahead head; all head fields read 0 while empty
    always_comb begin
        head      = mem[rd_ptr];
        rx_valid  = (cnt != '0);
        data_out  = rx_valid ? head[7:0] : 8'h00;
        err_p     = rx_valid & head[8];
        err_frame = rx_valid & head[9];
        rx_brk    = rx_valid & head[10];
        count     = cnt;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic        clk_r = 1'b0;
    logic        r_r, d_in, s_num, rd_en, ovr_clr;
    logic [15:0] div;
    logic [1:0]  d_len, para;
    logic [7:0]  data_out;
    logic        err_p, err_frame, rx_brk, rx_valid, err_ovr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int lat = 0;

    typedef struct {
        logic [7:0] d;
        int         dv;
        logic [1:0] len;
        logic [1:0] par;
        logic       snum;
        logic       pbit;
        logic       st1;
        logic       st2;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        logic       eb;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    vec_t vecs[11];
    exp_t sbq[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk_r(clk_r), .r_r(r_r), .d_in(d_in), .div(div), .d_len(d_len),
        .para(para), .s_num(s_num), .rd_en(rd_en), .ovr_clr(ovr_clr),
        .data_out(data_out), .err_p(err_p), .err_frame(err_frame),
        .rx_brk(rx_brk), .rx_valid(rx_valid), .err_ovr(err_ovr), .count(count)
    );

    always #5 clk_r = ~clk_r;

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b, input int bt);
        d_in = b;
        repeat (bt) @(negedge clk_r);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nd, input logic haspar,
                              input logic pb, input logic two, input logic st1,
                              input logic st2, input int bt);
        send_bit(1'b0, bt);
        for (int i = 0; i < nd; i++) send_bit(d[i], bt);
        if (haspar) send_bit(pb, bt);
        send_bit(st1, bt);
        if (two) send_bit(st2, bt);
        d_in = 1'b1;
    endtask

    task automatic expect_entry(input logic [7:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        e.d = d; e.p = p; e.f = f; e.b = b;
        sbq.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rx_valid && n < 600) begin
            @(negedge clk_r);
            n++;
        end
        check(name, rx_valid, 1);
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=%0h", tag, data_out);
        end else begin
            e = sbq.pop_front();
            check({tag, ".data"}, data_out, e.d);
            check({tag, ".err_p"}, err_p, e.p);
            check({tag, ".err_frame"}, err_frame, e.f);
            check({tag, ".rx_brk"}, rx_brk, e.b);
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk_r);
        rd_en = 1'b0;
    endtask

    task automatic cfg(input int dv, input logic [1:0] len, input logic [1:0] pr, input logic sn);
        div = 16'(dv); d_len = len; para = pr; s_num = sn;
    endtask

    initial begin
        vecs[0]  = '{8'hA5, 0, 2'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h53, 0, 2'd2, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h53, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h53, 0, 2'd2, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h53, 0, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'h53, 0, 2'd2, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h53, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h3C, 0, 2'd3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h81, 0, 2'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h0F, 2, 2'd1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h15, 1, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 0, 2'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{8'h00, 0, 2'd3, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};

        r_r = 1'b1; d_in = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0;
        cfg(0, 2'd3, 2'b00, 1'b0);
        repeat (3) @(negedge clk_r);
        r_r = 1'b0;
        @(negedge clk_r);
        check("rst.data_out", data_out, 0);
        check("rst.err_p", err_p, 0);
        check("rst.err_frame", err_frame, 0);
        check("rst.rx_brk", rx_brk, 0);
        check("rst.rx_valid", rx_valid, 0);
        check("rst.err_ovr", err_ovr, 0);
        check("rst.count", count, 0);

        // table-driven single frames
        for (int i = 0; i < 11; i++) begin
            int bt;
            bt = 16 * (vecs[i].dv + 1);
            cfg(vecs[i].dv, vecs[i].len, vecs[i].par, vecs[i].snum);
            @(negedge clk_r);
            send_frame(vecs[i].d, 5 + int'(vecs[i].len), vecs[i].par != 2'b00, vecs[i].pbit,
                       vecs[i].snum, vecs[i].st1, vecs[i].st2, bt);
            expect_entry(vecs[i].ed, vecs[i].ep, vecs[i].ef, vecs[i].eb);
            repeat (2 * bt) @(negedge clk_r);
            wait_valid($sformatf("vec%0d.valid", i));
            check($sformatf("vec%0d.count", i), count, 1);
            check_head($sformatf("vec%0d", i));
            pop_one();
            check($sformatf("vec%0d.empty", i), rx_valid, 0);
        end

        // short low glitch on an idle line
        cfg(3, 2'd3, 2'b00, 1'b0);
        @(negedge clk_r);
        d_in = 1'b0;
        repeat (6) @(negedge clk_r);
        d_in = 1'b1;
        repeat (300) @(negedge clk_r);
        check("glitch.rx_valid", rx_valid, 0);
        check("glitch.count", count, 0);
        check("glitch.err_ovr", err_ovr, 0);

        // line held low for three frame times
        cfg(0, 2'd3, 2'b00, 1'b0);
        @(negedge clk_r);
        d_in = 1'b0;
        repeat (3 * 10 * 16) @(negedge clk_r);
        d_in = 1'b1;
        expect_entry(8'h00, 1'b0, 1'b1, 1'b1);
        repeat (64) @(negedge clk_r);
        wait_valid("brk.valid");
        check("brk.count", count, 1);
        check_head("brk");
        pop_one();
        check("brk.empty", rx_valid, 0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        expect_entry(8'h11, 1'b0, 1'b0, 1'b0);
        repeat (32) @(negedge clk_r);
        wait_valid("post_brk.valid");
        check_head("post_brk");
        pop_one();

        // overrun: first frame also measures start-to-valid latency
        repeat (32) @(negedge clk_r);
        fork
            send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    @(negedge clk_r);
                    lat++;
                end
            end
        join
        check("latency.in_window", (lat >= 150 && lat <= 170), 1);
        expect_entry(8'h01, 1'b0, 1'b0, 1'b0);
        for (int f = 2; f <= 5; f++) begin
            repeat (32) @(negedge clk_r);
            send_frame(8'(f), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
            if (sbq.size() < DEPTH) expect_entry(8'(f), 1'b0, 1'b0, 1'b0);
        end
        repeat (16) @(negedge clk_r);
        check("ovr.count", count, 4);
        check("ovr.err_ovr", err_ovr, 1);
        check("ovr.head", data_out, sbq[0].d);

        // sixth frame with a pop in its push cycle
        repeat (32) @(negedge clk_r);
        fork
            send_frame(8'h06, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
            begin
                if (lat >= 2) begin
                    repeat (lat - 1) @(negedge clk_r);
                    rd_en = 1'b1;
                    @(negedge clk_r);
                    rd_en = 1'b0;
                end
            end
        join
        void'(sbq.pop_front());
        expect_entry(8'h06, 1'b0, 1'b0, 1'b0);
        repeat (16) @(negedge clk_r);
        check("pushpop.count", count, 4);
        check("pushpop.head", data_out, 8'h02);
        ovr_clr = 1'b1;
        @(negedge clk_r);
        ovr_clr = 1'b0;
        check("ovr_clr.err_ovr", err_ovr, 0);
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("drain%0d", k));
            pop_one();
        end
        check("drain.empty", rx_valid, 0);

        // reset during data bit 3 with an entry already queued
        repeat (32) @(negedge clk_r);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        repeat (32) @(negedge clk_r);
        check("pre_rst.count", count, 1);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        r_r = 1'b1;
        @(negedge clk_r);
        r_r = 1'b0;
        @(negedge clk_r);
        sbq.delete();
        check("midrst.rx_valid", rx_valid, 0);
        check("midrst.count", count, 0);
        check("midrst.data_out", data_out, 0);
        check("midrst.err_frame", err_frame, 0);
        repeat (100) @(negedge clk_r);
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        expect_entry(8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (32) @(negedge clk_r);
        wait_valid("post_rst.valid");
        check("post_rst.count", count, 1);
        check_head("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an internal baud generator, 16x oversampling with 3-sample majority vote, 5–8 data bits, none/odd/even parity, 1 or 2 stop bits, break detection and a receive FIFO with overrun flagging. It is the next-generation receive path of the UART IP. It runs from one system clock and programmable divisor instead of a set of per-rate clocks, and it presents received frames to the host through a show-ahead FIFO.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- DIV_W, 16, width of baud divisor
- clk_r  in  1  system clock
- r_r  in  1  synchronous active-high reset
- d_in  in  1  serial line, asynchronous, idle high
- div  in  DIV_W  oversample tick every div+1 clk_r cycles
- d_len  in  2  data bits = 5 + d_len (00→5 … 11→8)
- para  in  2  00 none, 10 even, 01/11 odd
- s_num  in  1  0 = 1 stop bit, 1 = 2 stop bits
- rd_en  in  1  pop FIFO head
- ovr_clr  in  1  clear err_ovr
- data_out  out  8  head data, LSB = first bit received, unused MSBs 0
- err_p  out  1  head parity error
- err_frame  out  1  head framing error
- rx_brk  out  1  head is a break frame
- rx_valid  out  1  FIFO not empty
- err_ovr  out  1  sticky overrun
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- d_in passes through a 2-flop synchronizer (d_s). All sampling uses d_s.
- Baud counter: counts 0..div and emits tick when it equals div. It is held at 0 in IDLE. div=0 gives a tick every cycle.
- os: 4-bit oversample counter advanced on tick. Samples are taken at os = 7, 8 and 9. The bit value is the majority of the 3 samples, resolved at the tick where os = 9.
- Configuration (d_len, para, s_num, div) is latched on leaving IDLE and is held for the whole frame.
- States:
  - IDLE: when d_s = 0, clear the baud counter and os, then enter START.
  - START: resolved bit 1 → glitch, return to IDLE with no error. Resolved bit 0 → at os wrap 15→0, enter DATA.
  - DATA: shift the resolved bit into position n. After 5 + d_len bits, go to PAR if para ≠ 00, otherwise go to STOP.
  - PAR: expected bit = ^data for even, ~^data for odd. Set perr if the received bit differs.
  - STOP: check each stop bit. If it resolves 0, set ferr. If it resolves 0 and data = 0 and the parity bit (if any) = 0, set brk.
  - Push after the os = 9 resolve of the last stop bit. With s_num = 1 and a bad first stop bit, push immediately and do not check the second.
  - After the push, go to IDLE, or to WAIT_HI if ferr is set.
  - WAIT_HI: stay until d_s = 1, then go to IDLE. A held-low line produces exactly one break entry.
- FIFO entry = {brk, ferr, perr, data[7:0]}. Show-ahead: outputs always reflect the head.
- Pop occurs when rd_en & rx_valid. rd_en while empty is ignored.
- Push while full with no pop in the same cycle: the frame is dropped, the FIFO is unchanged, and err_ovr is set.
- Push and pop in the same cycle, full or not: both happen and count is unchanged.
- err_ovr is sticky until ovr_clr. If ovr_clr and a new overrun fall in the same cycle, err_ovr stays 1.

## Timing
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-frame discards the partial frame. After reset the receiver needs d_s = 1→0 to start, so a line held low at reset exit starts a frame immediately.
- Synchronizer latency: 2 cycles from d_in to d_s.
- One bit lasts 16·(div+1) cycles. Center sample latency from the start edge on d_s is 8·(div+1)+1 cycles.
- Push-to-rx_valid: rx_valid, data_out, the flags and count update the cycle after the push cycle.
- Pop: the next head (or rx_valid = 0) appears the cycle after rd_en.
- Earliest next frame: the start edge may arrive at any time after the push. The receiver is in IDLE within 1 cycle of the push.

## Test plan
- Reset → all outputs 0. Then div=0, d_len=11, para=00, s_num=0, send 0xA5 → rx_valid=1 with data_out=0xA5, err_p=0, err_frame=0, count=1 ≈161 cycles after the start edge.
- d_len=10 (7 bits), para=10, send 0x53 with parity bit 0 → data_out=0x53, err_p=0. Resend with parity bit 1 → err_p=1. Repeat with para=01 → flags inverted.
- s_num=1, send 0x3C with second stop bit 0 → err_frame=1. A 6-cycle low glitch on an idle line (div=3) pushes no entry and raises no error.
- Hold d_in low for 3 frame times → exactly one entry with data_out=0, err_frame=1, rx_brk=1. After d_in returns high, 0x11 is received cleanly.
- DEPTH=4: send 5 frames without rd_en → count=4, err_ovr=1, and the head is still frame 1. Pop with rd_en in the same cycle as the 6th push → count stays 4. ovr_clr → err_ovr=0.
- Assert r_r for 1 cycle during data bit 3 → outputs 0, FIFO empty. The next full frame 0x7E is received correctly.
